// File: rtl/sng_pkg.sv
// sng_pkg: shared types, widths and arithmetic helpers for the sequential stochastic number
// generator (sng_sched). The quota and Weyl-step functions live here so that the scheduler RTL
// and any checking code use one definition.
//   BITSTREAM : bitstream length T
//   BASE      : first Weyl index (< T)
//   STRIDE    : Weyl stride (< T, coprime with T)
//   QUANT     : input sample width Q, two's complement
package sng_pkg;

  localparam int unsigned BITSTREAM = 64;
  localparam int unsigned BASE      = 2;
  localparam int unsigned STRIDE    = 17;
  localparam int unsigned QUANT     = 8;

  localparam int unsigned IW = $clog2(BITSTREAM);  // bit index width
  localparam int unsigned QW = IW + 1;             // quota width, holds 0..T
  localparam int unsigned PW = QUANT + IW + 1;     // u*T + rounding product width

  typedef enum logic [1:0] {
    StIdle,
    StBuild,
    StDone
  } sng_state_e;

  // s = round(u * T / 2^Q) with u = q + 2^(Q-1) mapped into 0..2^Q-1.
  function automatic logic [QW-1:0] sng_quota(input logic [QUANT-1:0] q);
    logic [QUANT:0] u;
    logic [PW-1:0]  p;
    u = {q[QUANT-1], q} + (QUANT+1)'(2 ** (QUANT - 1));
    p = PW'(u) * PW'(BITSTREAM) + PW'(2 ** (QUANT - 1));
    return QW'(p >> QUANT);
  endfunction

  // (idx + STRIDE) mod T with a single conditional subtract; valid because idx, STRIDE < T.
  function automatic logic [IW-1:0] weyl_next(input logic [IW-1:0] idx);
    logic [IW:0] sum;
    sum = {1'b0, idx} + (IW+1)'(STRIDE);
    if (sum >= (IW+1)'(BITSTREAM)) begin
      sum = sum - (IW+1)'(BITSTREAM);
    end
    return sum[IW-1:0];
  endfunction

endpackage

// File: rtl/sng_rr_arbiter.sv
// sng_rr_arbiter: combinational rotating-priority arbiter. Grants the first requester at or
// after ptr_i (wrapping modulo NReq).
//   req_i     : per-requester request
//   ptr_i     : highest-priority requester index
//   gnt_o     : one-hot grant, all-zero when nothing requests
//   gnt_idx_o : binary index of the granted requester (0 when none)
module sng_rr_arbiter #(
  parameter int unsigned NReq = 4,
  localparam int unsigned IdW = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NReq-1:0] gnt_o,
  output logic [IdW-1:0]  gnt_idx_o
);

  logic        found;
  logic [IdW:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      cand = {1'b0, ptr_i} + (IdW+1)'(i);
      if (cand >= (IdW+1)'(NReq)) begin
        cand = cand - (IdW+1)'(NReq);
      end
      if (!found && req_i[cand[IdW-1:0]]) begin
        found                   = 1'b1;
        gnt_o[cand[IdW-1:0]]    = 1'b1;
        gnt_idx_o               = cand[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/sng_sched.sv
// sng_sched: shared sequential stochastic number generator. A round-robin arbiter accepts one
// quantized sample, converts it to a quota s, and a Weyl index engine then sets one bit of the
// bitstream per cycle until s bits are set. The result is held, tagged with the requester ID,
// until the consumer takes it.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   iReqValid    : per-requester sample valid
//   iReqData     : packed samples, requester r at [r*QUANT +: QUANT]
//   oReqReady    : one-hot accept strobe (IDLE only)
//   oValid       : result valid (DONE)
//   iReady       : downstream ready
//   oBitstream   : generated bitstream
//   oId          : requester of the current result
//   oQuota       : latched quota s, present only when SNG_SCHED_QUOTA_OUT_EN is defined
module sng_sched
  import sng_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [NREQ-1:0]       iReqValid,
  input  logic [NREQ*QUANT-1:0] iReqData,
  output logic [NREQ-1:0]       oReqReady,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [BITSTREAM-1:0]  oBitstream,
  output logic [IdW-1:0]        oId
`ifdef SNG_SCHED_QUOTA_OUT_EN
  ,
  output logic [QW-1:0]         oQuota
`endif
);

  sng_state_e           state_q, state_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [QW-1:0]        k_q, k_d;
  logic [QW-1:0]        s_q, s_d;
  logic [BITSTREAM-1:0] bits_q, bits_d;
  logic [IdW-1:0]       id_q, id_d;

  logic [NREQ-1:0]      gnt;
  logic [IdW-1:0]       gnt_idx;
  logic [QUANT-1:0]     q_sel;
  logic [QW-1:0]        s_new;
  logic [IdW:0]         ptr_inc;

  sng_rr_arbiter #(
    .NReq (NREQ)
  ) u_arb (
    .req_i     (iReqValid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign q_sel   = iReqData[gnt_idx*QUANT +: QUANT];
  assign s_new   = sng_quota(q_sel);
  assign ptr_inc = {1'b0, gnt_idx} + (IdW+1)'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    k_d       = k_q;
    s_d       = s_q;
    bits_d    = bits_q;
    id_d      = id_q;
    oReqReady = '0;
    unique case (state_q)
      StIdle: begin
        oReqReady = gnt;
        // A grant is only raised for a valid requester, so any grant is an accept.
        if (|gnt) begin
          s_d    = s_new;
          id_d   = gnt_idx;
          bits_d = '0;
          idx_d  = IW'(BASE);
          k_d    = '0;
          ptr_d  = (ptr_inc >= (IdW+1)'(NREQ)) ? '0 : ptr_inc[IdW-1:0];
          state_d = (s_new == '0) ? StDone : StBuild;
        end
      end
      StBuild: begin
        bits_d[idx_q] = 1'b1;
        k_d           = k_q + QW'(1);
        idx_d         = weyl_next(idx_q);
        if (k_q == s_q - QW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (iReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= IW'(BASE);
      k_q     <= '0;
      s_q     <= '0;
      bits_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      s_q     <= s_d;
      bits_q  <= bits_d;
      id_q    <= id_d;
    end
  end

  assign oValid     = (state_q == StDone);
  assign oBitstream = bits_q;
  assign oId        = id_q;
`ifdef SNG_SCHED_QUOTA_OUT_EN
  assign oQuota     = s_q;
`endif

endmodule

// File: tb/tb_sng_sched.sv
// tb_sng_sched: directed, table-driven bench for sng_sched (NREQ=4, T=64, BASE=2, STRIDE=17,
// Q=8). Expected quotas are hand-computed; expected bitstreams come from an independent
// modulo model of the Weyl sequence.
module tb_sng_sched;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [3:0]  iReqValid;
  logic [31:0] iReqData;
  logic [3:0]  oReqReady;
  logic        oValid;
  logic        iReady;
  logic [63:0] oBitstream;
  logic [1:0]  oId;
`ifdef SNG_SCHED_QUOTA_OUT_EN
  logic [6:0]  oQuota;
`endif

  sng_sched #(
    .NREQ (4)
  ) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iReqValid  (iReqValid),
    .iReqData   (iReqData),
    .oReqReady  (oReqReady),
    .oValid     (oValid),
    .iReady     (iReady),
    .oBitstream (oBitstream),
    .oId        (oId)
`ifdef SNG_SCHED_QUOTA_OUT_EN
    ,
    .oQuota     (oQuota)
`endif
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Bits set after n Weyl steps: indices (BASE + j*STRIDE) mod T for j < n.
  function automatic logic [63:0] model_bits(input int n);
    logic [63:0] b;
    b = '0;
    for (int j = 0; j < n; j++) b[(2 + j * 17) % 64] = 1'b1;
    return b;
  endfunction

  typedef struct {
    int         r;
    logic [7:0] q;
    int         s;
  } vec_t;

  vec_t vecs[10];

  // Present one sample on requester r, follow it to DONE and acknowledge it.
  task automatic run_one(input int r, input logic [7:0] q, input int exp_s, input string tag);
    int lat;
    @(negedge iClk);
    iReqValid         = '0;
    iReqValid[r]      = 1'b1;
    iReqData[r*8 +: 8] = q;
    #1;
    check({tag, "_grant"}, 64'(oReqReady), 64'(1) << r);
    @(posedge iClk);
    #1;
    iReqValid = '0;
    lat = 1;
    while (!oValid && lat < 200) begin
      check({tag, "_build"}, oBitstream, model_bits(lat - 1));
      @(posedge iClk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'((exp_s == 0) ? 1 : exp_s + 1));
    check({tag, "_bits"}, oBitstream, model_bits(exp_s));
    check({tag, "_popcount"}, 64'($countones(oBitstream)), 64'(exp_s));
    check({tag, "_id"}, 64'(oId), 64'(r));
`ifdef SNG_SCHED_QUOTA_OUT_EN
    check({tag, "_quota"}, 64'(oQuota), 64'(exp_s));
`endif
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    check({tag, "_ack"}, 64'(oValid), 64'(0));
  endtask

  task automatic pulse_reset();
    @(negedge iClk);
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [63:0] held;

    vecs[0] = '{0, 8'h00, 32};
    vecs[1] = '{0, 8'h81, 0};   // -127
    vecs[2] = '{0, 8'h80, 0};   // -128
    vecs[3] = '{0, 8'h7F, 64};  // 127
    vecs[4] = '{1, 8'hC0, 16};  // -64
    vecs[5] = '{2, 8'h40, 48};  // 64
    vecs[6] = '{3, 8'h82, 1};   // -126
    vecs[7] = '{1, 8'h7D, 63};  // 125
    vecs[8] = '{2, 8'hFF, 32};  // -1
    vecs[9] = '{3, 8'h01, 32};

    iRst_n    = 1'b0;
    iReqValid = '0;
    iReqData  = '0;
    iReady    = 1'b0;
    #12;
    check("rst_valid", 64'(oValid), 64'(0));
    check("rst_ready", 64'(oReqReady), 64'(0));
    check("rst_bits", oBitstream, 64'(0));
    check("rst_id", 64'(oId), 64'(0));
    @(negedge iClk);
    iRst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].r, vecs[i].q, vecs[i].s, $sformatf("vec%0d", i));
    end

    // All four requesters continuously valid from a fresh pointer.
    pulse_reset();
    iReqData  = {4{8'hC0}};
    iReqValid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rr%0d_grant", g), 64'(oReqReady), 64'(1) << (g % 4));
      @(posedge iClk);
      #1;
      lat = 1;
      while (!oValid && lat < 200) begin
        @(posedge iClk);
        #1;
        lat++;
      end
      check($sformatf("rr%0d_latency", g), 64'(lat), 64'(17));
      check($sformatf("rr%0d_bits", g), oBitstream, model_bits(16));
      check($sformatf("rr%0d_id", g), 64'(oId), 64'(g % 4));
      iReady = 1'b1;
      @(posedge iClk);
      #1;
      iReady = 1'b0;
      // Back in IDLE: not yet accepted, next grant offered (one bubble).
      check($sformatf("rr%0d_bubble", g), 64'(oValid), 64'(0));
    end
    check("rr_next_grant", 64'(oReqReady), 64'(2));
    iReqValid = '0;

    // Stall in DONE with another requester waiting.
    pulse_reset();
    iReqData  = {4{8'hC0}};
    iReqValid = 4'b0001;
    @(posedge iClk);
    #1;
    iReqValid = '0;
    lat = 1;
    while (!oValid && lat < 200) begin
      @(posedge iClk);
      #1;
      lat++;
    end
    check("stall_latency", 64'(lat), 64'(17));
    held = model_bits(16);
    iReqValid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("stall%0d_valid", c), 64'(oValid), 64'(1));
      check($sformatf("stall%0d_bits", c), oBitstream, held);
      check($sformatf("stall%0d_id", c), 64'(oId), 64'(0));
      check($sformatf("stall%0d_ready", c), 64'(oReqReady), 64'(0));
      @(posedge iClk);
      #1;
    end
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    check("stall_release_valid", 64'(oValid), 64'(0));
    check("stall_release_ready", 64'(oReqReady), 64'(4'b0010));
    iReqValid = '0;

    // Asynchronous reset in the middle of BUILD.
    @(negedge iClk);
    iReqData[7:0] = 8'h00;
    iReqValid     = 4'b0001;
    @(posedge iClk);
    #1;
    iReqValid = '0;
    repeat (10) @(posedge iClk);
    #1;
    check("midrst_progress", 64'($countones(oBitstream)), 64'(10));
    #1;
    iRst_n = 1'b0;
    #1;
    check("midrst_bits", oBitstream, 64'(0));
    check("midrst_valid", 64'(oValid), 64'(0));
    check("midrst_id", 64'(oId), 64'(0));
    check("midrst_ready", 64'(oReqReady), 64'(0));
    @(negedge iClk);
    iRst_n = 1'b1;
    run_one(0, 8'h00, 32, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
